// File: rtl/fc_classifier.sv
// fc_classifier: fully-connected output stage behind the conv/pool stage.
// It buffers one frame of IN_LEN signed features. It then runs NUM_CLASSES dot
// products on a single shared multiply-accumulator: one bias cycle, then IN_LEN
// MAC cycles, then one emit cycle per class. It emits a saturated score for each
// class and, at the end of the frame, the index of the winning class.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   feat_valid   feature word valid
//   feat_ready   block can accept a feature word (only in the load phase)
//   feat_data    signed feature word
//   feat_last    upstream end-of-frame marker (checked; framing uses the count)
//   w_we         coefficient write enable (honoured only in the load phase)
//   w_addr       coefficient address c*(IN_LEN+1)+k, where k==IN_LEN is the bias
//   w_data       signed weight or bias
//   score_valid  one-cycle pulse per class score
//   score_idx    class of the current score
//   score_data   signed saturated score
//   done         one-cycle pulse with the last score of a frame
//   class_id     argmax of the last completed frame
//   len_err      sticky framing error
module fc_classifier #(
    parameter int unsigned IN_LEN      = 12,
    parameter int unsigned NUM_CLASSES = 4,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ACC_W       = 40,
    parameter int unsigned SHIFT       = 0,
    localparam int unsigned AW = $clog2(NUM_CLASSES * (IN_LEN + 1)),
    localparam int unsigned CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     feat_valid,
    output logic                     feat_ready,
    input  logic signed [DATA_W-1:0] feat_data,
    input  logic                     feat_last,
    input  logic                     w_we,
    input  logic [AW-1:0]            w_addr,
    input  logic signed [DATA_W-1:0] w_data,
    output logic                     score_valid,
    output logic [CW-1:0]            score_idx,
    output logic signed [DATA_W-1:0] score_data,
    output logic                     done,
    output logic [CW-1:0]            class_id,
    output logic                     len_err
);

    localparam int unsigned KW    = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam int unsigned NCOEF = NUM_CLASSES * (IN_LEN + 1);
    localparam logic [KW-1:0] LastK = KW'(IN_LEN - 1);
    localparam logic [CW-1:0] LastC = CW'(NUM_CLASSES - 1);
    localparam logic signed [ACC_W-1:0] SatMax =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SatMin =
        {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {StLoad, StBias, StMac, StEmit} state_e;

    state_e state_q, state_d;

    logic signed [DATA_W-1:0] feat_mem [IN_LEN];
    logic signed [DATA_W-1:0] coef_mem [NCOEF];

    logic [KW-1:0]            cnt_q;
    logic [KW-1:0]            k_q;
    logic [CW-1:0]            c_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [DATA_W-1:0] max_q;
    logic [CW-1:0]            arg_q;

    logic                     score_valid_q;
    logic [CW-1:0]            score_idx_q;
    logic signed [DATA_W-1:0] score_data_q;
    logic                     done_q;
    logic [CW-1:0]            class_id_q;
    logic                     len_err_q;

    logic                       accept;
    logic [AW-1:0]              row_base;
    logic [AW-1:0]              mac_addr;
    logic [AW-1:0]              bias_addr;
    logic signed [DATA_W-1:0]   feat_rd;
    logic signed [DATA_W-1:0]   coef_rd;
    logic signed [DATA_W-1:0]   bias_rd;
    logic signed [2*DATA_W-1:0] feat_ext;
    logic signed [2*DATA_W-1:0] coef_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [DATA_W-1:0]   score_sat;
    logic                       upd_max;
    logic signed [DATA_W-1:0]   max_next;
    logic [CW-1:0]              arg_next;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad: if (accept && (cnt_q == LastK)) state_d = StBias;
            StBias: state_d = StMac;
            StMac:  if (k_q == LastK) state_d = StEmit;
            StEmit: state_d = (c_q == LastC) ? StLoad : StBias;
            default: state_d = StLoad;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        feat_ready = (state_q == StLoad);
    end

    assign accept = feat_valid && feat_ready;

    // ---------------- Storage ----------------
    // Coefficients are retained across reset.
    always_ff @(posedge clk) begin
        if (w_we && (state_q == StLoad) && (32'(w_addr) < NCOEF)) begin
            coef_mem[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            feat_mem[cnt_q] <= feat_data;
        end
    end

    // ---------------- Datapath ----------------
    always_comb begin
        row_base  = AW'(32'(c_q) * (IN_LEN + 1));
        mac_addr  = row_base + AW'(k_q);
        bias_addr = row_base + AW'(IN_LEN);
        feat_rd   = feat_mem[k_q];
        coef_rd   = coef_mem[mac_addr];
        bias_rd   = coef_mem[bias_addr];

        // The full-width product is formed from explicitly sign-extended operands.
        feat_ext  = $signed({{DATA_W{feat_rd[DATA_W-1]}}, feat_rd});
        coef_ext  = $signed({{DATA_W{coef_rd[DATA_W-1]}}, coef_rd});
        prod      = feat_ext * coef_ext;
        prod_ext  = $signed({{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod});
        bias_ext  = $signed({{(ACC_W - DATA_W){bias_rd[DATA_W-1]}}, bias_rd}) <<< SHIFT;

        shifted = acc_q >>> SHIFT;
        if (shifted > SatMax) begin
            score_sat = SatMax[DATA_W-1:0];
        end else if (shifted < SatMin) begin
            score_sat = SatMin[DATA_W-1:0];
        end else begin
            score_sat = shifted[DATA_W-1:0];
        end

        // Strict greater-than keeps the lower index on ties.
        upd_max  = (c_q == '0) || (score_sat > max_q);
        max_next = upd_max ? score_sat : max_q;
        arg_next = upd_max ? c_q : arg_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q         <= '0;
            k_q           <= '0;
            c_q           <= '0;
            acc_q         <= '0;
            max_q         <= '0;
            arg_q         <= '0;
            score_valid_q <= 1'b0;
            score_idx_q   <= '0;
            score_data_q  <= '0;
            done_q        <= 1'b0;
            class_id_q    <= '0;
            len_err_q     <= 1'b0;
        end else begin
            score_valid_q <= 1'b0;
            done_q        <= 1'b0;

            if (accept) begin
                cnt_q <= (cnt_q == LastK) ? '0 : cnt_q + KW'(1);
                if (feat_last != (cnt_q == LastK)) begin
                    len_err_q <= 1'b1;
                end
            end

            unique case (state_q)
                StLoad: begin
                    c_q <= '0;
                end
                StBias: begin
                    acc_q <= bias_ext;
                    k_q   <= '0;
                end
                StMac: begin
                    acc_q <= acc_q + prod_ext;
                    k_q   <= k_q + KW'(1);
                end
                StEmit: begin
                    score_valid_q <= 1'b1;
                    score_idx_q   <= c_q;
                    score_data_q  <= score_sat;
                    max_q         <= max_next;
                    arg_q         <= arg_next;
                    if (c_q == LastC) begin
                        done_q     <= 1'b1;
                        class_id_q <= arg_next;
                        c_q        <= '0;
                    end else begin
                        c_q <= c_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign score_valid = score_valid_q;
    assign score_idx   = score_idx_q;
    assign score_data  = score_data_q;
    assign done        = done_q;
    assign class_id    = class_id_q;
    assign len_err     = len_err_q;

endmodule

// File: tb/tb_fc_classifier.sv
// Self-checking bench for fc_classifier. The reference model computes each class
// score directly as bias + sum(feature*weight), saturated, with argmax on the
// lowest index for ties.
module tb_fc_classifier;

    localparam int IN_LEN      = 12;
    localparam int NUM_CLASSES = 4;
    localparam int DATA_W      = 16;
    localparam int ACC_W       = 40;
    localparam int SHIFT       = 0;
    localparam int AW          = $clog2(NUM_CLASSES * (IN_LEN + 1));
    localparam int CW          = $clog2(NUM_CLASSES);
    localparam int FRAME_CYC   = NUM_CLASSES * (IN_LEN + 2);

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     feat_valid = 1'b0;
    logic                     feat_ready;
    logic signed [DATA_W-1:0] feat_data = '0;
    logic                     feat_last = 1'b0;
    logic                     w_we = 1'b0;
    logic [AW-1:0]            w_addr = '0;
    logic signed [DATA_W-1:0] w_data = '0;
    logic                     score_valid;
    logic [CW-1:0]            score_idx;
    logic signed [DATA_W-1:0] score_data;
    logic                     done;
    logic [CW-1:0]            class_id;
    logic                     len_err;

    fc_classifier #(
        .IN_LEN(IN_LEN),
        .NUM_CLASSES(NUM_CLASSES),
        .DATA_W(DATA_W),
        .ACC_W(ACC_W),
        .SHIFT(SHIFT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .feat_valid(feat_valid),
        .feat_ready(feat_ready),
        .feat_data(feat_data),
        .feat_last(feat_last),
        .w_we(w_we),
        .w_addr(w_addr),
        .w_data(w_data),
        .score_valid(score_valid),
        .score_idx(score_idx),
        .score_data(score_data),
        .done(done),
        .class_id(class_id),
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int wm [NUM_CLASSES][IN_LEN];
    int bm [NUM_CLASSES];
    int fv [IN_LEN];
    int exp_sc [NUM_CLASSES];
    int exp_cls;

    int cap_sc [NUM_CLASSES];
    int cap_idx [NUM_CLASSES];
    int cap_n, cap_cls, cap_done, cap_first, cap_done_at, cap_ready_early, cap_ready_at_done;
    int send_ok;

    // ---------------- Reference model ----------------
    function automatic int model_score(int c);
        longint s;
        s = longint'(bm[c]) * (longint'(1) << SHIFT);
        for (int k = 0; k < IN_LEN; k++) s += longint'(fv[k]) * longint'(wm[c][k]);
        s = s >>> SHIFT;
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return int'(s);
    endfunction

    task automatic compute_expected();
        for (int c = 0; c < NUM_CLASSES; c++) exp_sc[c] = model_score(c);
        exp_cls = 0;
        for (int c = 1; c < NUM_CLASSES; c++) if (exp_sc[c] > exp_sc[exp_cls]) exp_cls = c;
    endtask

    function automatic int rnd(bit full);
        if (full) return int'($signed(DATA_W'($urandom)));
        return int'($urandom_range(0, 600)) - 300;
    endfunction

    task automatic set_coefs_uniform(int w, int b);
        for (int c = 0; c < NUM_CLASSES; c++) begin
            bm[c] = b;
            for (int k = 0; k < IN_LEN; k++) wm[c][k] = w;
        end
    endtask

    task automatic set_feats_ramp();
        for (int k = 0; k < IN_LEN; k++) fv[k] = k + 1;
    endtask

    // ---------------- Stimulus helpers (entered just after a negedge) ----------------
    task automatic load_coefs();
        for (int c = 0; c < NUM_CLASSES; c++) begin
            for (int k = 0; k <= IN_LEN; k++) begin
                w_we   = 1'b1;
                w_addr = AW'(c * (IN_LEN + 1) + k);
                w_data = DATA_W'((k == IN_LEN) ? bm[c] : wm[c][k]);
                @(negedge clk);
            end
        end
        w_we = 1'b0;
    endtask

    task automatic send_frame(int first, int last_pos, bit gaps);
        int budget;
        send_ok = 1;
        for (int i = first; i < IN_LEN; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                feat_valid = 1'b0;
                @(negedge clk);
            end
            feat_valid = 1'b1;
            feat_data  = DATA_W'(fv[i]);
            feat_last  = (i == last_pos);
            budget = 0;
            while (!feat_ready && budget < 500) begin
                @(negedge clk);
                budget++;
            end
            if (!feat_ready) begin
                send_ok = 0;
                break;
            end
            @(negedge clk);
        end
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    // Passive observer; cycle numbers count negedges after the last accept.
    task automatic capture_frame(int budget);
        cap_n = 0;
        cap_cls = -1;
        cap_done = 0;
        cap_first = -1;
        cap_done_at = -1;
        cap_ready_early = 0;
        cap_ready_at_done = 0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            cap_sc[c] = 99999;
            cap_idx[c] = -1;
        end
        for (int i = 1; i <= budget && cap_done == 0; i++) begin
            @(negedge clk);
            if (score_valid) begin
                if (cap_first < 0) cap_first = i;
                if (cap_n < NUM_CLASSES) begin
                    cap_sc[cap_n]  = int'(score_data);
                    cap_idx[cap_n] = int'(score_idx);
                end
                cap_n++;
            end
            if (done) begin
                cap_done = 1;
                cap_done_at = i;
                cap_cls = int'(class_id);
                cap_ready_at_done = int'(feat_ready);
            end else if (feat_ready) begin
                cap_ready_early++;
            end
        end
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (feat_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", feat_ready); end
        total++; if (score_valid !== 1'b0) begin bad++; $display("FAIL rst_svalid got=%b want=0", score_valid); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (score_idx !== '0) begin bad++; $display("FAIL rst_sidx got=%0d want=0", score_idx); end
        total++; if (score_data !== '0) begin bad++; $display("FAIL rst_sdata got=%0d want=0", score_data); end
        total++; if (class_id !== '0) begin bad++; $display("FAIL rst_class got=%0d want=0", class_id); end
        total++; if (len_err !== 1'b0) begin bad++; $display("FAIL rst_lenerr got=%b want=0", len_err); end
    endtask

    task automatic test_ones();
        set_coefs_uniform(1, 0);
        set_feats_ramp();
        compute_expected();
        load_coefs();
        send_frame(0, IN_LEN - 1, 1'b0);
        capture_frame(300);
        total++; if (send_ok != 1) begin bad++; $display("FAIL t1_send got=%0d want=1", send_ok); end
        total++; if (cap_done != 1) begin bad++; $display("FAIL t1_done got=%0d want=1", cap_done); end
        total++; if (cap_n != NUM_CLASSES) begin bad++; $display("FAIL t1_nscores got=%0d want=%0d", cap_n, NUM_CLASSES); end
        for (int c = 0; c < NUM_CLASSES; c++) begin
            total++; if (cap_sc[c] != exp_sc[c]) begin bad++; $display("FAIL t1_score%0d got=%0d want=%0d", c, cap_sc[c], exp_sc[c]); end
            total++; if (cap_idx[c] != c) begin bad++; $display("FAIL t1_idx%0d got=%0d want=%0d", c, cap_idx[c], c); end
        end
        total++; if (cap_cls != exp_cls) begin bad++; $display("FAIL t1_class got=%0d want=%0d", cap_cls, exp_cls); end
        total++; if (cap_first != IN_LEN + 2) begin bad++; $display("FAIL t1_latency got=%0d want=%0d", cap_first, IN_LEN + 2); end
        total++; if (cap_done_at != FRAME_CYC) begin bad++; $display("FAIL t1_frame_time got=%0d want=%0d", cap_done_at, FRAME_CYC); end
        total++; if (cap_ready_early != 0) begin bad++; $display("FAIL t1_ready_busy got=%0d want=0", cap_ready_early); end
    endtask

    task automatic test_bias();
        set_coefs_uniform(1, 0);
        bm[2] = 100;
        set_feats_ramp();
        compute_expected();
        load_coefs();
        send_frame(0, IN_LEN - 1, 1'b0);
        capture_frame(300);
        total++; if (cap_done != 1) begin bad++; $display("FAIL t2_done got=%0d want=1", cap_done); end
        for (int c = 0; c < NUM_CLASSES; c++) begin
            total++; if (cap_sc[c] != exp_sc[c]) begin bad++; $display("FAIL t2_score%0d got=%0d want=%0d", c, cap_sc[c], exp_sc[c]); end
        end
        total++; if (cap_cls != exp_cls) begin bad++; $display("FAIL t2_class got=%0d want=%0d", cap_cls, exp_cls); end
    endtask

    task automatic test_saturation();
        for (int pass = 0; pass < 2; pass++) begin
            set_coefs_uniform((pass == 0) ? 32767 : -32767, 0);
            for (int k = 0; k < IN_LEN; k++) fv[k] = 32767;
            compute_expected();
            load_coefs();
            send_frame(0, IN_LEN - 1, 1'b0);
            capture_frame(300);
            total++; if (cap_done != 1) begin bad++; $display("FAIL t3_done pass=%0d got=%0d want=1", pass, cap_done); end
            for (int c = 0; c < NUM_CLASSES; c++) begin
                total++; if (cap_sc[c] != exp_sc[c]) begin bad++; $display("FAIL t3_sat pass=%0d class=%0d got=%0d want=%0d", pass, c, cap_sc[c], exp_sc[c]); end
            end
            total++; if (cap_cls != exp_cls) begin bad++; $display("FAIL t3_class pass=%0d got=%0d want=%0d", pass, cap_cls, exp_cls); end
        end
    endtask

    task automatic test_back_to_back();
        int f2 [IN_LEN];
        for (int c = 0; c < NUM_CLASSES; c++) begin
            bm[c] = rnd(1'b0);
            for (int k = 0; k < IN_LEN; k++) wm[c][k] = rnd(1'b0);
        end
        for (int k = 0; k < IN_LEN; k++) begin
            fv[k] = rnd(1'b0);
            f2[k] = rnd(1'b0);
        end
        compute_expected();
        load_coefs();
        send_frame(0, IN_LEN - 1, 1'b0);
        // Frame 2's first word is presented and held throughout compute.
        for (int k = 0; k < IN_LEN; k++) fv[k] = f2[k];
        feat_valid = 1'b1;
        feat_data  = DATA_W'(fv[0]);
        feat_last  = 1'b0;
        capture_frame(300);
        total++; if (cap_ready_early != 0) begin bad++; $display("FAIL t4_ready_busy got=%0d want=0", cap_ready_early); end
        total++; if (cap_ready_at_done != 1) begin bad++; $display("FAIL t4_ready_at_done got=%0d want=1", cap_ready_at_done); end
        for (int c = 0; c < NUM_CLASSES; c++) begin
            total++; if (cap_sc[c] != exp_sc[c]) begin bad++; $display("FAIL t4_f1_score%0d got=%0d want=%0d", c, cap_sc[c], exp_sc[c]); end
        end
        total++; if (cap_cls != exp_cls) begin bad++; $display("FAIL t4_f1_class got=%0d want=%0d", cap_cls, exp_cls); end
        @(negedge clk);
        send_frame(1, IN_LEN - 1, 1'b0);
        compute_expected();
        capture_frame(300);
        total++; if (cap_first != IN_LEN + 2) begin bad++; $display("FAIL t4_f2_latency got=%0d want=%0d", cap_first, IN_LEN + 2); end
        for (int c = 0; c < NUM_CLASSES; c++) begin
            total++; if (cap_sc[c] != exp_sc[c]) begin bad++; $display("FAIL t4_f2_score%0d got=%0d want=%0d", c, cap_sc[c], exp_sc[c]); end
        end
        total++; if (cap_cls != exp_cls) begin bad++; $display("FAIL t4_f2_class got=%0d want=%0d", cap_cls, exp_cls); end
    endtask

    task automatic test_reset_mid();
        int seen_sv, seen_done;
        set_coefs_uniform(1, 0);
        load_coefs();
        for (int k = 0; k < IN_LEN; k++) fv[k] = rnd(1'b0);
        send_frame(0, IN_LEN - 1, 1'b0);
        seen_sv = 0;
        for (int i = 1; i <= IN_LEN + 8; i++) begin
            @(negedge clk);
            if (score_valid) seen_sv++;
        end
        total++; if (seen_sv != 1) begin bad++; $display("FAIL t5_pre_scores got=%0d want=1", seen_sv); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        total++; if (feat_ready !== 1'b1) begin bad++; $display("FAIL t5_ready got=%b want=1", feat_ready); end
        total++; if (class_id !== '0) begin bad++; $display("FAIL t5_class_clr got=%0d want=0", class_id); end
        seen_sv = 0;
        seen_done = 0;
        for (int i = 0; i < FRAME_CYC + 20; i++) begin
            @(negedge clk);
            if (score_valid) seen_sv++;
            if (done) seen_done++;
        end
        total++; if (seen_sv != 0) begin bad++; $display("FAIL t5_aborted_scores got=%0d want=0", seen_sv); end
        total++; if (seen_done != 0) begin bad++; $display("FAIL t5_aborted_done got=%0d want=0", seen_done); end
        set_feats_ramp();
        compute_expected();
        send_frame(0, IN_LEN - 1, 1'b0);
        capture_frame(300);
        total++; if (cap_done != 1) begin bad++; $display("FAIL t5_done got=%0d want=1", cap_done); end
        for (int c = 0; c < NUM_CLASSES; c++) begin
            total++; if (cap_sc[c] != exp_sc[c]) begin bad++; $display("FAIL t5_score%0d got=%0d want=%0d", c, cap_sc[c], exp_sc[c]); end
        end
        total++; if (cap_cls != exp_cls) begin bad++; $display("FAIL t5_class got=%0d want=%0d", cap_cls, exp_cls); end
    endtask

    task automatic test_len_err();
        set_coefs_uniform(1, 0);
        load_coefs();
        set_feats_ramp();
        compute_expected();
        send_frame(0, 4, 1'b0);
        repeat (5) @(negedge clk);
        // Write attempt while computing: must be ignored.
        w_we   = 1'b1;
        w_addr = '0;
        w_data = 16'sd999;
        @(negedge clk);
        w_we = 1'b0;
        capture_frame(300);
        total++; if (len_err !== 1'b1) begin bad++; $display("FAIL t6_lenerr got=%b want=1", len_err); end
        total++; if (cap_n != NUM_CLASSES) begin bad++; $display("FAIL t6_nscores got=%0d want=%0d", cap_n, NUM_CLASSES); end
        for (int c = 0; c < NUM_CLASSES; c++) begin
            total++; if (cap_sc[c] != exp_sc[c]) begin bad++; $display("FAIL t6_score%0d got=%0d want=%0d", c, cap_sc[c], exp_sc[c]); end
        end
        send_frame(0, IN_LEN - 1, 1'b0);
        capture_frame(300);
        for (int c = 0; c < NUM_CLASSES; c++) begin
            total++; if (cap_sc[c] != exp_sc[c]) begin bad++; $display("FAIL t6_wprot_score%0d got=%0d want=%0d", c, cap_sc[c], exp_sc[c]); end
        end
        total++; if (len_err !== 1'b1) begin bad++; $display("FAIL t6_lenerr_sticky got=%b want=1", len_err); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            bit full;
            full = (f % 2) == 1;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                bm[c] = rnd(full);
                for (int k = 0; k < IN_LEN; k++) wm[c][k] = rnd(full);
            end
            for (int k = 0; k < IN_LEN; k++) fv[k] = rnd(full);
            compute_expected();
            load_coefs();
            send_frame(0, IN_LEN - 1, 1'b1);
            capture_frame(300);
            total++; if (cap_done != 1) begin bad++; $display("FAIL rnd_done f=%0d got=%0d want=1", f, cap_done); end
            total++; if (cap_first != IN_LEN + 2) begin bad++; $display("FAIL rnd_latency f=%0d got=%0d want=%0d", f, cap_first, IN_LEN + 2); end
            for (int c = 0; c < NUM_CLASSES; c++) begin
                total++; if (cap_sc[c] != exp_sc[c]) begin bad++; $display("FAIL rnd_score f=%0d class=%0d got=%0d want=%0d", f, c, cap_sc[c], exp_sc[c]); end
                total++; if (cap_idx[c] != c) begin bad++; $display("FAIL rnd_idx f=%0d slot=%0d got=%0d want=%0d", f, c, cap_idx[c], c); end
            end
            total++; if (cap_cls != exp_cls) begin bad++; $display("FAIL rnd_class f=%0d got=%0d want=%0d", f, cap_cls, exp_cls); end
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_bias();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_len_err();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
